// File: rtl/palette_lut_pkg.sv
// Shared definitions for the banked palette LUT: default geometry and
// small constant/helper functions used by the top level and the RAM.
package palette_lut_pkg;

    localparam int DEF_INDEX_WIDTH = 8;
    localparam int DEF_COLOR_WIDTH = 16;
    localparam int DEF_NUM_BANKS   = 4;

    // Widest colour the grey-scale helper can produce.
    localparam int MAX_COLOR_WIDTH = 64;

    // Ceiling log2 for elaboration-time width checks.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // Bypass colour: the index left-aligned in the colour word, low bits zero.
    function automatic logic [MAX_COLOR_WIDTH-1:0] idx_to_grey(
        input logic [MAX_COLOR_WIDTH-1:0] index,
        input int                         index_width,
        input int                         color_width
    );
        return index << (color_width - index_width);
    endfunction

endpackage

// File: rtl/palette_lut_ram.sv
// Simple dual-port palette RAM: one write port, one read port with read
// enable, read-first on address collision, one cycle read latency.
// Contents are not reset so the array maps onto block RAM.
module palette_lut_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Write and registered read share one edge; the non-blocking update makes
    // a same-address read return the old word (read-first).
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/axis_palette_lut_banked.sv
// AXI4-Stream palette lookup with NUM_BANKS runtime-loadable palettes.
// Bank and bypass selection are sampled only on accepted start-of-frame
// beats and already apply to that beat. Two-stage pipe: RAM read, then
// output register.
//
// Handshake: a beat moves on a clock edge where valid and ready are both
// high. The whole pipe advances on cen = m_axis_tready | ~m_axis_tvalid,
// s_axis_tready equals cen, and while cen is low every stage (including the
// RAM output) holds, so m_axis_tdata/tuser stay stable while stalled.
module axis_palette_lut_banked
    import palette_lut_pkg::*;
#(
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int COLOR_WIDTH = DEF_COLOR_WIDTH,
    parameter int NUM_BANKS   = DEF_NUM_BANKS,
    parameter int BANK_WIDTH  = 2
) (
    input  logic                   axis_aclk,
    input  logic                   axis_aresetn,
    input  logic [INDEX_WIDTH-1:0] s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tuser,
    output logic [COLOR_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tuser,
    input  logic                   cfg_wr_en,
    input  logic [BANK_WIDTH-1:0]  cfg_wr_bank,
    input  logic [INDEX_WIDTH-1:0] cfg_wr_addr,
    input  logic [COLOR_WIDTH-1:0] cfg_wr_data,
    input  logic [BANK_WIDTH-1:0]  cfg_bank_sel,
    input  logic                   cfg_bypass,
    output logic [BANK_WIDTH-1:0]  active_bank,
    output logic                   bank_switched,
    output logic                   wr_hit_active
);

    localparam int ADDR_WIDTH = BANK_WIDTH + INDEX_WIDTH;

    if (NUM_BANKS < 2 || BANK_WIDTH != clog2(NUM_BANKS) || (1 << BANK_WIDTH) != NUM_BANKS) begin : g_bad_banks
        $error("NUM_BANKS must be a power of two >= 2 and BANK_WIDTH its log2");
    end
    if (COLOR_WIDTH < INDEX_WIDTH || COLOR_WIDTH > MAX_COLOR_WIDTH) begin : g_bad_color
        $error("COLOR_WIDTH must be >= INDEX_WIDTH and <= MAX_COLOR_WIDTH");
    end

    logic                   cen;
    logic                   accept;
    logic                   frame_start;
    logic [BANK_WIDTH-1:0]  sel_bank;
    logic                   sel_bypass;
    logic                   bypass_q;
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [COLOR_WIDTH-1:0] ram_rdata;
    logic                   s1_valid;
    logic                   s1_user;
    logic                   s1_bypass;
    logic [INDEX_WIDTH-1:0] s1_index;

    assign cen           = m_axis_tready | ~m_axis_tvalid;
    assign s_axis_tready = cen;
    assign accept        = s_axis_tvalid & cen;
    assign frame_start   = accept & s_axis_tuser;

    // A start-of-frame beat looks itself up with the newly requested setting.
    assign sel_bank   = frame_start ? cfg_bank_sel : active_bank;
    assign sel_bypass = frame_start ? cfg_bypass   : bypass_q;
    assign rd_addr    = {sel_bank, s_axis_tdata};
    assign wr_addr    = {cfg_wr_bank, cfg_wr_addr};

    palette_lut_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (COLOR_WIDTH)
    ) u_ram (
        .clk     (axis_aclk),
        .wr_en   (cfg_wr_en),
        .wr_addr (wr_addr),
        .wr_data (cfg_wr_data),
        .rd_en   (cen),
        .rd_addr (rd_addr),
        .rd_data (ram_rdata)
    );

    // Stage 1: side-band that travels alongside the RAM read.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            s1_valid  <= 1'b0;
            s1_user   <= 1'b0;
            s1_bypass <= 1'b0;
            s1_index  <= '0;
        end else if (cen) begin
            s1_valid  <= s_axis_tvalid;
            s1_user   <= s_axis_tvalid & s_axis_tuser;
            s1_bypass <= sel_bypass;
            s1_index  <= s_axis_tdata;
        end
    end

    // Stage 2: output register; bypass beats discard the RAM word.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (cen) begin
            m_axis_tvalid <= s1_valid;
            m_axis_tuser  <= s1_user;
            if (s1_valid) begin
                m_axis_tdata <= s1_bypass
                    ? COLOR_WIDTH'(idx_to_grey(MAX_COLOR_WIDTH'(s1_index), INDEX_WIDTH, COLOR_WIDTH))
                    : ram_rdata;
            end
        end
    end

    // Frame-boundary bank/bypass state and the one-cycle status pulses.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            active_bank   <= '0;
            bypass_q      <= 1'b0;
            bank_switched <= 1'b0;
            wr_hit_active <= 1'b0;
        end else begin
            bank_switched <= frame_start && (cfg_bank_sel != active_bank);
            wr_hit_active <= cfg_wr_en && (cfg_wr_bank == sel_bank);
            if (frame_start) begin
                active_bank <= cfg_bank_sel;
                bypass_q    <= cfg_bypass;
            end
        end
    end

endmodule

// File: tb/tb_axis_palette_lut_banked.sv
// Directed bench for axis_palette_lut_banked: the driver pushes the expected
// {tuser, colour} of each accepted beat into exp_q, the monitor pops and
// compares whenever an output beat transfers.
module tb_axis_palette_lut_banked;

    logic        clk;
    logic        rst_n;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tuser;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_user;
    logic        cfg_wr_en;
    logic [1:0]  cfg_wr_bank;
    logic [7:0]  cfg_wr_addr;
    logic [15:0] cfg_wr_data;
    logic [1:0]  cfg_bank_sel;
    logic        cfg_bypass;
    logic [1:0]  active_bank;
    logic        bank_switched;
    logic        wr_hit_active;

    logic [16:0] exp_q[$];
    logic [15:0] pal_model [4][256];
    logic [1:0]  model_bank;
    logic        model_bypass;
    int          n_checks;
    int          n_fail;
    logic        hold_valid;
    logic [15:0] hold_data;
    logic        hold_user;

    axis_palette_lut_banked dut (
        .axis_aclk     (clk),
        .axis_aresetn  (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tuser  (s_tuser),
        .m_axis_tdata  (m_data),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready),
        .m_axis_tuser  (m_user),
        .cfg_wr_en     (cfg_wr_en),
        .cfg_wr_bank   (cfg_wr_bank),
        .cfg_wr_addr   (cfg_wr_addr),
        .cfg_wr_data   (cfg_wr_data),
        .cfg_bank_sel  (cfg_bank_sel),
        .cfg_bypass    (cfg_bypass),
        .active_bank   (active_bank),
        .bank_switched (bank_switched),
        .wr_hit_active (wr_hit_active)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        s_tvalid  = 1'b0;
        s_tuser   = 1'b0;
        m_ready   = 1'b1;
        cfg_wr_en = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pal_write(input logic [1:0] bank, input logic [7:0] addr, input logic [15:0] data);
        cfg_wr_en   = 1'b1;
        cfg_wr_bank = bank;
        cfg_wr_addr = addr;
        cfg_wr_data = data;
        @(posedge clk);
        #1;
        cfg_wr_en = 1'b0;
        pal_model[bank][addr] = data;
        check("wr_hit_load", 32'(wr_hit_active), 32'(bank == model_bank));
    endtask

    // rmode: 0 = sink always ready, 1 = random ready, 2 = sink never ready.
    // An optional palette write is issued in the first cycle (use with rmode 0).
    task automatic send(input logic [7:0] idx, input logic user, input int rmode,
                        input logic wen, input logic [1:0] wbank,
                        input logic [7:0] waddr, input logic [15:0] wdata);
        logic        acc;
        logic [1:0]  bank;
        logic        byp;
        logic [15:0] exp_d;
        logic        exp_sw;
        logic        exp_hit;
        int          guard;
        s_tvalid    = 1'b1;
        s_tdata     = idx;
        s_tuser     = user;
        cfg_wr_en   = wen;
        cfg_wr_bank = wbank;
        cfg_wr_addr = waddr;
        cfg_wr_data = wdata;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 200) begin
            m_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            acc = s_tready;
            @(posedge clk);
            #1;
            cfg_wr_en = 1'b0;
            guard++;
        end
        if (!acc) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            bank   = user ? cfg_bank_sel : model_bank;
            byp    = user ? cfg_bypass : model_bypass;
            exp_sw = user && (cfg_bank_sel != model_bank);
            exp_d  = byp ? {idx, 8'h00} : pal_model[bank][idx];
            exp_q.push_back({user, exp_d});
            exp_hit = wen && (wbank == bank);
            if (wen) pal_model[wbank][waddr] = wdata;
            model_bank   = bank;
            model_bypass = byp;
            check("bank_switched", 32'(bank_switched), 32'(exp_sw));
            check("active_bank", 32'(active_bank), 32'(bank));
            if (wen) check("wr_hit_active", 32'(wr_hit_active), 32'(exp_hit));
        end
    endtask

    task automatic drain();
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        m_ready  = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_idle", 32'(m_valid), 32'd0);
    endtask

    // Monitor: compares transfers against exp_q and checks stall stability.
    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst_n) begin
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                if (m_valid) begin
                    check("stall_data", 32'(m_data), 32'(hold_data));
                    check("stall_user", 32'(m_user), 32'(hold_user));
                end
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("m_tdata", 32'(m_data), 32'(e[15:0]));
                    check("m_tuser", 32'(m_user), 32'(e[16]));
                end
                hold_valid = 1'b0;
            end else if (m_valid) begin
                hold_valid = 1'b1;
                hold_data  = m_data;
                hold_user  = m_user;
            end else begin
                hold_valid = 1'b0;
            end
        end
    end

    // Directed sequence
    initial begin
        n_checks     = 0;
        n_fail       = 0;
        hold_valid   = 1'b0;
        model_bank   = 2'd0;
        model_bypass = 1'b0;
        rst_n        = 1'b0;
        s_tdata      = '0;
        s_tvalid     = 1'b0;
        s_tuser      = 1'b0;
        m_ready      = 1'b1;
        cfg_wr_en    = 1'b0;
        cfg_wr_bank  = '0;
        cfg_wr_addr  = '0;
        cfg_wr_data  = '0;
        cfg_bank_sel = 2'd0;
        cfg_bypass   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_tvalid", 32'(m_valid), 32'd0);
        check("rst_tuser", 32'(m_user), 32'd0);
        check("rst_tdata", 32'(m_data), 32'd0);
        check("rst_active_bank", 32'(active_bank), 32'd0);
        check("rst_bank_switched", 32'(bank_switched), 32'd0);
        check("rst_wr_hit", 32'(wr_hit_active), 32'd0);
        check("rst_tready", 32'(s_tready), 32'd1);
        idle(1);

        // Load bank0 = 0x1000+i, bank1 = 0x2000+i
        for (int i = 0; i < 256; i++) pal_write(2'd0, 8'(i), 16'h1000 + 16'(i));
        for (int i = 0; i < 256; i++) pal_write(2'd1, 8'(i), 16'h2000 + 16'(i));
        idle(1);

        // Frame of indices 0..255 from bank0, latency 2, back-to-back output
        for (int i = 0; i < 256; i++) begin
            send(8'(i), i == 0, 0, 1'b0, 2'd0, 8'd0, 16'd0);
            check("latency_valid", 32'(m_valid), 32'(i != 0));
        end
        idle(1);
        check("tail_valid", 32'(m_valid), 32'd1);
        drain();

        // Mid-frame bank request is deferred to the next tuser beat
        for (int i = 0; i < 20; i++) begin
            if (i == 10) cfg_bank_sel = 2'd1;
            send(8'(i), i == 0, 0, 1'b0, 2'd0, 8'd0, 16'd0);
        end
        send(8'd3, 1'b1, 0, 1'b0, 2'd0, 8'd0, 16'd0);
        send(8'd4, 1'b0, 0, 1'b0, 2'd0, 8'd0, 16'd0);
        send(8'd5, 1'b0, 0, 1'b0, 2'd0, 8'd0, 16'd0);
        drain();

        // 1000-beat frame on bank1 under random backpressure
        for (int i = 0; i < 1000; i++) begin
            send(8'((i * 37 + 11) % 256), i == 0, 1, 1'b0, 2'd0, 8'd0, 16'd0);
        end
        drain();

        // Read-first collision on the active bank, write to an inactive bank
        send(8'd5, 1'b0, 0, 1'b1, 2'd1, 8'd5, 16'hBEEF);
        send(8'd5, 1'b0, 0, 1'b0, 2'd0, 8'd0, 16'd0);
        send(8'd6, 1'b0, 0, 1'b1, 2'd3, 8'd6, 16'h3333);
        send(8'd6, 1'b0, 0, 1'b0, 2'd0, 8'd0, 16'd0);
        drain();

        // Bypass frame: index left-aligned, cleared only at next tuser
        cfg_bypass = 1'b1;
        send(8'hA5, 1'b1, 0, 1'b0, 2'd0, 8'd0, 16'd0);
        check("bypass_lat1", 32'(m_valid), 32'd0);
        idle(1);
        check("bypass_lat2", 32'(m_valid), 32'd1);
        check("bypass_data", 32'(m_data), 32'h0000A500);
        cfg_bypass = 1'b0;
        send(8'h12, 1'b0, 0, 1'b0, 2'd0, 8'd0, 16'd0);
        cfg_bank_sel = 2'd0;
        send(8'h12, 1'b1, 0, 1'b0, 2'd0, 8'd0, 16'd0);
        drain();

        // Reset with two beats held in the pipe
        cfg_bank_sel = 2'd1;
        send(8'd9, 1'b1, 2, 1'b0, 2'd0, 8'd0, 16'd0);
        send(8'd10, 1'b0, 2, 1'b0, 2'd0, 8'd0, 16'd0);
        check("pipe_full", 32'(m_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_tvalid", 32'(m_valid), 32'd0);
        check("async_bank", 32'(active_bank), 32'd0);
        exp_q.delete();
        model_bank   = 2'd0;
        model_bypass = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        check("post_rst_valid", 32'(m_valid), 32'd0);
        send(8'd7, 1'b0, 0, 1'b0, 2'd0, 8'd0, 16'd0);
        send(8'd200, 1'b0, 0, 1'b0, 2'd0, 8'd0, 16'd0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_palette_lut_banked.md
Name: axis_palette_lut_banked

Overview:
- Parametrised successor to the single-palette AXI4-Stream LUT. Maps an INDEX_WIDTH pixel index to a COLOR_WIDTH colour.
- Holds NUM_BANKS palettes in internal RAM, so no external BRAM controller is needed.
- Palettes are loaded at runtime through a simple write port. Banks switch only on frame boundaries (tuser = start of frame).
- Sits between the video scaler/AGC output and the display colour path. Bypass mode emits grey-scale.

Parameters:
- INDEX_WIDTH, 8, pixel index width; one palette holds 2^INDEX_WIDTH entries.
- COLOR_WIDTH, 16, output colour width; must be >= INDEX_WIDTH.
- NUM_BANKS, 4, number of palettes; power of two, >= 2.
- BANK_WIDTH, 2, log2(NUM_BANKS); checked by elaboration assertion.

Ports:
- axis_aclk  in  1  clock for all logic.
- axis_aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  INDEX_WIDTH  pixel index.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat ready.
- s_axis_tuser  in  1  start of frame.
- m_axis_tdata  out  COLOR_WIDTH  colour.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  output beat ready.
- m_axis_tuser  out  1  start of frame, delayed with its beat.
- cfg_wr_en  in  1  palette write strobe.
- cfg_wr_bank  in  BANK_WIDTH  bank to write.
- cfg_wr_addr  in  INDEX_WIDTH  entry to write.
- cfg_wr_data  in  COLOR_WIDTH  colour value.
- cfg_bank_sel  in  BANK_WIDTH  requested bank, sampled at frame start.
- cfg_bypass  in  1  requested bypass, sampled at frame start.
- active_bank  out  BANK_WIDTH  bank currently applied.
- bank_switched  out  1  one-cycle pulse when the active bank changes.
- wr_hit_active  out  1  one-cycle pulse when a write targets the active bank.

Behaviour:
- Reset values:
  - m_axis_tvalid = 0, m_axis_tuser = 0, m_axis_tdata = 0.
  - active_bank = 0, bypass state = 0, bank_switched = 0, wr_hit_active = 0.
  - RAM contents are not reset.
- Pipeline structure: two stages.
  - S1: RAM read, synchronous, latency 1.
  - S2: output register.
  - Each stage carries a valid bit and tuser.
- Advance enable: cen = m_axis_tready | ~m_axis_tvalid.
  - s_axis_tready = cen.
  - RAM read enable = cen.
  - When cen = 0, all stage registers hold and the RAM output is held.
- Latency and throughput:
  - Accept at cycle N gives m_axis_tvalid at N+2 when there is no backpressure.
  - One beat per clock sustained.
  - No beat is dropped or duplicated under any tready pattern.
- Frame-boundary sampling: on an accepted beat with s_axis_tuser = 1:
  - active_bank <= cfg_bank_sel and bypass <= cfg_bypass.
  - The new selection already applies to that beat's own address; the RAM address is {cfg_bank_sel, index} combinationally.
  - bank_switched pulses in the next cycle only if the value changed.
- Mid-frame changes: cfg_bank_sel and cfg_bypass changes mid-frame are ignored until the next accepted tuser beat.
- Bypass output: m_axis_tdata = index left-aligned in COLOR_WIDTH with lower bits zero.
  - Uses the same 2-cycle latency; the RAM result is discarded.
- Palette writes:
  - Writes are accepted every cycle regardless of stream state; the write address is {cfg_wr_bank, cfg_wr_addr}.
  - A simultaneous read and write of the same address is read-first: the read returns the old value and the new value is visible from the next read.
  - wr_hit_active pulses in the next cycle when cfg_wr_bank equals the bank that will be active after this cycle's update.
  - A write to an inactive bank never disturbs the stream.
- Backpressure during a bank switch: the held output keeps the colour looked up with its own bank. Data already inside the pipe is never re-looked-up.
- Reset mid-stream:
  - The pipeline flushes with no partial beat out; m_axis_tvalid drops asynchronously.
  - The first beat after reset uses bank 0 unless it carries tuser.
- Width rules: RAM depth = NUM_BANKS * 2^INDEX_WIDTH, word width = COLOR_WIDTH.
  - No arithmetic beyond address concatenation.

Decomposition:
- Shared package palette_lut_pkg holds:
  - defaults for INDEX_WIDTH, COLOR_WIDTH and NUM_BANKS;
  - the function clog2;
  - the bypass alignment function idx_to_grey(index).
- Sub-module palette_lut_ram: simple dual-port RAM.
  - One write port and one read port with read enable, read-first, latency 1.
  - Inferred as block RAM.
- The top level holds the pipeline valid/tuser registers, bank and bypass state, and the pulses.

Test Plan:
- Load bank0[i] = 0x1000 + i and bank1[i] = 0x2000 + i, cfg_bank_sel = 0, then stream a frame of indices 0..255 with tready = 1: expect 0x1000..0x10FF with first valid 2 cycles after first accept and 256 consecutive beats.
- Set cfg_bank_sel = 1 mid-frame: output stays on bank0 until the next tuser beat. That beat returns 0x2000 + idx, tuser is forwarded, bank_switched pulses once and active_bank = 1.
- Drive random tready (about 50 %) over a 1000-beat frame: the output sequence equals the input sequence mapped through the active bank, with no loss or duplication, and tdata/tuser are stable while tvalid & ~tready.
- Write bank1[5] = 0xBEEF in the same cycle a beat reads index 5 from active bank1: that beat gets the old value, the next index-5 beat gets 0xBEEF, and wr_hit_active pulses. A write to bank 3 gives no pulse.
- With cfg_bypass = 1 at frame start, COLOR_WIDTH = 16 and input 0xA5: expect 0xA500 at latency 2. Bypass clears only at the next tuser beat.
- Assert axis_aresetn low with 2 beats in the pipe: tvalid goes 0 immediately and active_bank returns to 0. After release, bank contents are retained and the lookup from bank0 is correct.
